// File: rtl/i2s_codec_emulator.sv
// Purpose: I2S codec emulator (bus master). It generates BCLK and the two LRCK frame clocks,
//          serializes a buffered 24-bit ADC sample pair into a left-justified 64-slot frame,
//          and can optionally capture the DAC serial stream.
// Latency: a pair accepted before a frame start goes out on AUD_ADCDAT from that frame start.
//          dac_valid pulses on the rising BCLK tick of slot 55.
// Backpressure: adc_ready is low while the one-entry holding buffer is full. The serial clocks
//          free-run and never stall; an empty buffer at frame start sends a zero frame and sets underrun.
// Ports:   CLOCK_50 and reset (synchronous, active high).
//          adc_left/adc_right/adc_valid/adc_ready: sample-pair handshake.
//          AUD_BCLK, AUD_ADCLRCK, AUD_DACLRCK, AUD_ADCDAT: serial outputs. AUD_DACDAT: serial input.
//          dac_left/dac_right/dac_valid: captured DAC pair. underrun: sticky flag.
// Option:  define I2S_DAC_CAPTURE_EN to build the DAC capture path. Without it,
//          AUD_DACDAT is ignored and the dac_* outputs are held at 0.
module i2s_codec_emulator #(
    parameter int BCLK_HALF = 16
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [23:0] adc_left,
    input  logic [23:0] adc_right,
    input  logic        adc_valid,
    output logic        adc_ready,
    output logic        AUD_BCLK,
    output logic        AUD_ADCLRCK,
    output logic        AUD_DACLRCK,
    output logic        AUD_ADCDAT,
    input  logic        AUD_DACDAT,
    output logic [23:0] dac_left,
    output logic [23:0] dac_right,
    output logic        dac_valid,
    output logic        underrun
);

    localparam int HW = $clog2(BCLK_HALF);

    logic [HW-1:0] half_cnt;
    logic          bclk_q;
    logic          bclk_tick;
    logic          fall_tick;
    logic [5:0]    slot;
    logic [5:0]    slot_nxt;
    logic          frame_start;
    logic          accept;

    logic [23:0]   hold_left;
    logic [23:0]   hold_right;
    logic          hold_full;

    logic [23:0]   tx_left;
    logic [23:0]   tx_right;
    logic [23:0]   tx_left_nxt;
    logic [23:0]   tx_right_nxt;
    logic [23:0]   chan_word;
    logic          adcdat_q;
    logic          adcdat_nxt;
    logic          underrun_q;

    assign bclk_tick   = (half_cnt == HW'(BCLK_HALF - 1));
    assign fall_tick   = bclk_tick & bclk_q;
    assign slot_nxt    = slot + 6'd1;
    assign frame_start = fall_tick & (slot == 6'd63);
    assign accept      = adc_valid & ~hold_full;

    // Frame words for the upcoming slot. At frame start, take the holding buffer if it is full;
    // otherwise send zeros. A pair accepted on the frame-start cycle itself is too late for this frame.
    always_comb begin
        tx_left_nxt  = tx_left;
        tx_right_nxt = tx_right;
        if (frame_start) begin
            if (hold_full) begin
                tx_left_nxt  = hold_left;
                tx_right_nxt = hold_right;
            end else begin
                tx_left_nxt  = '0;
                tx_right_nxt = '0;
            end
        end
    end

    // Left-justified: channel slot k carries bit 23-k for k < 24 and pads with zeros after that.
    always_comb begin
        chan_word  = slot_nxt[5] ? tx_right_nxt : tx_left_nxt;
        adcdat_nxt = 1'b0;
        if (slot_nxt[4:0] < 5'd24) begin
            adcdat_nxt = chan_word[5'd23 - slot_nxt[4:0]];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            half_cnt   <= '0;
            bclk_q     <= 1'b0;
            slot       <= 6'd63;
            adcdat_q   <= 1'b0;
            tx_left    <= '0;
            tx_right   <= '0;
            hold_left  <= '0;
            hold_right <= '0;
            hold_full  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            half_cnt <= bclk_tick ? '0 : half_cnt + HW'(1);
            if (bclk_tick) begin
                bclk_q <= ~bclk_q;
            end
            if (fall_tick) begin
                slot     <= slot_nxt;
                adcdat_q <= adcdat_nxt;
                tx_left  <= tx_left_nxt;
                tx_right <= tx_right_nxt;
            end
            // Accept is only possible when the buffer is empty, so it never collides with a
            // frame start that drains a full buffer.
            if (accept) begin
                hold_left  <= adc_left;
                hold_right <= adc_right;
                hold_full  <= 1'b1;
            end else if (frame_start) begin
                hold_full <= 1'b0;
            end
            if (frame_start && !hold_full) begin
                underrun_q <= 1'b1;
            end
        end
    end

    assign adc_ready   = ~hold_full;
    assign AUD_BCLK    = bclk_q;
    assign AUD_ADCLRCK = ~slot[5];
    assign AUD_DACLRCK = ~slot[5];
    assign AUD_ADCDAT  = adcdat_q;
    assign underrun    = underrun_q;

`ifdef I2S_DAC_CAPTURE_EN
    logic        rise_tick;
    logic        cap_en;
    logic [23:0] cap_left;
    logic [23:0] cap_right;
    logic [23:0] dac_left_q;
    logic [23:0] dac_right_q;
    logic        dac_valid_q;

    // DAC data is stable mid-slot, so it is sampled on the rising BCLK tick.
    assign rise_tick = bclk_tick & ~bclk_q;
    assign cap_en    = rise_tick & (slot[4:0] < 5'd24);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cap_left    <= '0;
            cap_right   <= '0;
            dac_left_q  <= '0;
            dac_right_q <= '0;
            dac_valid_q <= 1'b0;
        end else begin
            dac_valid_q <= 1'b0;
            if (cap_en) begin
                if (slot[5]) begin
                    cap_right <= {cap_right[22:0], AUD_DACDAT};
                end else begin
                    cap_left <= {cap_left[22:0], AUD_DACDAT};
                end
            end
            // Slot 55 carries the last right-channel bit. Publish it directly so the pair is
            // complete on this same tick.
            if (rise_tick && (slot == 6'd55)) begin
                dac_left_q  <= cap_left;
                dac_right_q <= {cap_right[22:0], AUD_DACDAT};
                dac_valid_q <= 1'b1;
            end
        end
    end

    assign dac_left  = dac_left_q;
    assign dac_right = dac_right_q;
    assign dac_valid = dac_valid_q;
`else
    logic unused_dacdat;
    assign unused_dacdat = AUD_DACDAT;
    assign dac_left      = '0;
    assign dac_right     = '0;
    assign dac_valid     = 1'b0;
`endif

endmodule

// File: doc/i2s_codec_emulator.md
I2S_CODEC_EMULATOR -- requirements
Module: i2s_codec_emulator

Interface
REQ-001 Parameter BCLK_HALF, default 16, meaning CLOCK_50 cycles per BCLK half-period; legal range is 2 or more.
REQ-002 CLOCK_50  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 adc_left, adc_right  in  24 each  signed sample pair to be serialized toward the receiver.
REQ-005 adc_valid  in  1  sample pair offered; adc_ready  out  1  holding buffer empty.
REQ-006 AUD_BCLK, AUD_ADCLRCK, AUD_DACLRCK, AUD_ADCDAT  out  1 each  serial clock, frame clocks, ADC serial data.
REQ-007 AUD_DACDAT  in  1  DAC serial data from the receiver.
REQ-008 dac_left, dac_right  out  24 each  captured DAC pair; dac_valid  out  1  one-cycle pulse when the pair updates.
REQ-009 underrun  out  1  sticky flag; a frame started with the holding buffer empty.

Function
REQ-010 The block SHALL assert bclk_tick when the half counter equals BCLK_HALF-1, then clear the counter; AUD_BCLK SHALL toggle on every tick.
REQ-011 A tick that takes AUD_BCLK from 1 to 0 is a falling tick, and the block SHALL advance the 6-bit slot counter modulo 64 on each falling tick.
REQ-012 AUD_ADCLRCK and AUD_DACLRCK SHALL be identical and equal to the inverse of slot[5]: 1 for the left channel (slots 0-31) and 0 for the right channel (slots 32-63).
REQ-013 The frame SHALL be left-justified: for channel slot k = slot[4:0], AUD_ADCDAT SHALL carry shift bit 23-k when k<24 and 0 otherwise, updated on falling ticks.
REQ-014 The handshake SHALL complete on a cycle with adc_valid and adc_ready both high: the pair loads into the holding buffer and adc_ready drops on the next cycle.
REQ-015 At frame start (the falling tick where slot wraps 63->0), a full holding buffer SHALL move into the left and right shift registers, and adc_ready SHALL rise on the next cycle.
REQ-016 At frame start with an empty buffer, the block SHALL transmit zeros for the whole frame and set underrun.
REQ-017 When a handshake and frame start coincide with an empty buffer, the block SHALL treat the new pair as too late: it enters the buffer, the current frame is zeros, and underrun is set.
REQ-018 On a rising tick with channel slot k<24, the block SHALL shift AUD_DACDAT into the current channel's capture register, MSB first.
REQ-019 On the rising tick of right-channel slot 23 (slot 55), the block SHALL update dac_left and dac_right together and pulse dac_valid high for exactly one CLOCK_50 cycle.
REQ-020 The serializer SHALL not depend on adc_valid timing; BCLK and LRCK SHALL run free and never stall.

Reset
REQ-021 While reset is high, the block SHALL hold: half counter 0, AUD_BCLK 0, slot 63, both LRCK outputs 0, AUD_ADCDAT 0, and all shift and holding registers 0.
REQ-022 While reset is high, the block SHALL also hold: adc_ready 1, dac_left/right 0, dac_valid 0, underrun 0.
REQ-023 After reset, the first frame start SHALL occur on the second tick, 2*BCLK_HALF cycles after reset deasserts.
REQ-024 Reset asserted mid-frame SHALL abort the frame and discard any partial DAC capture, with no dac_valid pulse.

Configuration
REQ-025 With macro I2S_DAC_CAPTURE_EN defined, the block SHALL compile in the DAC capture path described in REQ-018 and REQ-019.
REQ-026 With I2S_DAC_CAPTURE_EN undefined, the block SHALL ignore AUD_DACDAT, hold dac_left and dac_right at 0 and dac_valid at 0, and implement no capture registers; the ADC path SHALL be unchanged.

Verification
REQ-027 Reset check, BCLK_HALF=4: release reset at cycle 0 -> BCLK rises at cycle 4, falls at cycle 8, and LRCK becomes 1 at cycle 8.
REQ-028 Single pair: offer left 0xA5A5A5 / right 0x3C3C3C before the first frame -> ADCDAT carries 24 MSB-first bits of each channel followed by 8 zeros, and adc_ready rises one cycle after frame start.
REQ-029 Underrun: no adc_valid -> the frame is all zeros and underrun=1; the flag stays set until reset.
REQ-030 Loopback (macro defined): tie AUD_DACDAT to AUD_ADCDAT and feed 0x800001 / 0x7FFFFF -> one dac_valid pulse, dac_left=0x800001, dac_right=0x7FFFFF.
REQ-031 Simultaneous events: raise adc_valid on the frame-start cycle with the buffer empty -> zero frame, underrun=1, and the pair transmits in the following frame.
REQ-032 Mid-frame reset at slot 40 -> no dac_valid pulse, and after release all outputs match their reset values.
